// File: rtl/control_unit_p_if.sv
// Handshake/bus bundle between the processor control FSM and its datapath.
// master = control unit (drives strobes), slave = datapath/environment side.
interface control_unit_p_if #(
  parameter int OP_W  = 4,
  parameter int RF_AW = 4,
  parameter int D_AW  = 8,
  parameter int PC_W  = 7
);
  localparam int IW = OP_W + RF_AW + D_AW;

  logic             run;
  logic [IW-1:0]    ir;
  logic             alu_zero;

  logic             pc_clr;
  logic             pc_up;
  logic             pc_ld;
  logic [PC_W-1:0]  pc_ld_val;
  logic             ir_ld;
  logic [D_AW-1:0]  d_addr;
  logic             d_wr;
  logic [1:0]       rf_s;
  logic [D_AW-1:0]  rf_imm;
  logic [RF_AW-1:0] rf_w_addr;
  logic             rf_w_wr;
  logic [RF_AW-1:0] rf_ra_addr;
  logic [RF_AW-1:0] rf_rb_addr;
  logic [2:0]       alu_s;
  logic [3:0]       state;
  logic             halted;

  modport master (
    input  run, ir, alu_zero,
    output pc_clr, pc_up, pc_ld, pc_ld_val, ir_ld, d_addr, d_wr, rf_s, rf_imm,
           rf_w_addr, rf_w_wr, rf_ra_addr, rf_rb_addr, alu_s, state, halted
  );

  modport slave (
    output run, ir, alu_zero,
    input  pc_clr, pc_up, pc_ld, pc_ld_val, ir_ld, d_addr, d_wr, rf_s, rf_imm,
           rf_w_addr, rf_w_wr, rf_ra_addr, rf_rb_addr, alu_s, state, halted
  );
endinterface

// File: rtl/control_unit_p.sv
// Parametrised fetch/decode/execute control FSM. All outputs are decoded
// combinationally from the current state and IR fields.
module control_unit_p #(
  parameter int OP_W    = 4,
  parameter int RF_AW   = 4,
  parameter int D_AW    = 8,
  parameter int PC_W    = 7,
  parameter int MEM_LAT = 1
) (
  input logic            clk,
  input logic            reset_n,
  control_unit_p_if.master bus
);
  localparam int IW    = OP_W + RF_AW + D_AW;
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9,
    S_LOADI  = 4'd10,
    S_JPZ    = 4'd11
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [OP_W-1:0]  op;
  logic [RF_AW-1:0] ra, rb, rw;
  logic [D_AW-1:0]  addr;

  assign op   = bus.ir[IW-1 -: OP_W];
  assign ra   = bus.ir[D_AW+RF_AW-1 -: RF_AW];
  assign addr = bus.ir[D_AW-1:0];
  assign rb   = bus.ir[2*RF_AW-1:RF_AW];
  assign rw   = bus.ir[RF_AW-1:0];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every output and next-state value is defaulted first, so no path can infer a latch.
  always_comb begin
    state_d        = state_q;
    cnt_d          = '0;
    bus.pc_clr     = 1'b0;
    bus.pc_up      = 1'b0;
    bus.pc_ld      = 1'b0;
    bus.pc_ld_val  = '0;
    bus.ir_ld      = 1'b0;
    bus.d_addr     = '0;
    bus.d_wr       = 1'b0;
    bus.rf_s       = 2'd0;
    bus.rf_imm     = '0;
    bus.rf_w_addr  = '0;
    bus.rf_w_wr    = 1'b0;
    bus.rf_ra_addr = '0;
    bus.rf_rb_addr = '0;
    bus.alu_s      = 3'd0;
    bus.state      = state_q;
    bus.halted     = 1'b0;

    unique case (state_q)
      S_INIT: begin
        bus.pc_clr = 1'b1;
        if (bus.run) state_d = S_FETCH;
      end
      S_FETCH: begin
        bus.pc_up = 1'b1;
        bus.ir_ld = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        case (op)
          OP_W'(0): state_d = S_NOOP;
          OP_W'(1): state_d = S_STORE;
          OP_W'(2): state_d = S_LOAD_A;
          OP_W'(3): state_d = S_ADD;
          OP_W'(4): state_d = S_SUB;
          OP_W'(6): state_d = S_LOADI;
          OP_W'(7): state_d = S_JPZ;
          default:  state_d = S_HALT;
        endcase
      end
      S_NOOP: state_d = S_FETCH;
      S_LOAD_A: begin
        // Counter is zero on entry because every other state clears it.
        bus.d_addr = addr;
        if (cnt_q == CNT_LAST) state_d = S_LOAD_B;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      S_LOAD_B: begin
        bus.d_addr    = addr;
        bus.rf_s      = 2'd1;
        bus.rf_w_addr = ra;
        bus.rf_w_wr   = 1'b1;
        state_d       = S_FETCH;
      end
      S_STORE: begin
        bus.d_addr     = addr;
        bus.rf_ra_addr = ra;
        bus.d_wr       = 1'b1;
        state_d        = S_FETCH;
      end
      S_ADD, S_SUB: begin
        bus.rf_ra_addr = ra;
        bus.rf_rb_addr = rb;
        bus.rf_w_addr  = rw;
        bus.rf_w_wr    = 1'b1;
        bus.alu_s      = (state_q == S_ADD) ? 3'd1 : 3'd2;
        state_d        = S_FETCH;
      end
      S_HALT: bus.halted = 1'b1;
      S_LOADI: begin
        bus.rf_s      = 2'd2;
        bus.rf_imm    = addr;
        bus.rf_w_addr = ra;
        bus.rf_w_wr   = 1'b1;
        state_d       = S_FETCH;
      end
      S_JPZ: begin
        bus.rf_ra_addr = ra;
        bus.pc_ld_val  = addr[PC_W-1:0];
        bus.pc_ld      = bus.alu_zero;
        state_d        = S_FETCH;
      end
      default: state_d = S_INIT;
    endcase
  end
endmodule

// File: tb/tb_control_unit_p.sv
// Self-checking bench for control_unit_p: per-instruction expected cycle traces
// are built from the instruction-level behaviour and compared every cycle.
module tb_control_unit_p;
  localparam int OP_W    = 4;
  localparam int RF_AW   = 4;
  localparam int D_AW    = 8;
  localparam int PC_W    = 7;
  localparam int MEM_LAT = 3;
  localparam int HALT_CY = 10;

  typedef struct {
    logic       pc_clr, pc_up, pc_ld;
    logic [6:0] pc_ld_val;
    logic       ir_ld;
    logic [7:0] d_addr;
    logic       d_wr;
    logic [1:0] rf_s;
    logic [7:0] rf_imm;
    logic [3:0] rf_w_addr;
    logic       rf_w_wr;
    logic [3:0] ra, rb;
    logic [2:0] alu_s;
    logic [3:0] state;
    logic       halted;
  } exp_t;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  exp_t q[$];

  control_unit_p_if #(.OP_W(OP_W), .RF_AW(RF_AW), .D_AW(D_AW), .PC_W(PC_W)) bus ();

  control_unit_p #(
    .OP_W(OP_W), .RF_AW(RF_AW), .D_AW(D_AW), .PC_W(PC_W), .MEM_LAT(MEM_LAT)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rec(input string tag, input exp_t e);
    check({tag, ".state"},      32'(bus.state),      32'(e.state));
    check({tag, ".pc_clr"},     32'(bus.pc_clr),     32'(e.pc_clr));
    check({tag, ".pc_up"},      32'(bus.pc_up),      32'(e.pc_up));
    check({tag, ".pc_ld"},      32'(bus.pc_ld),      32'(e.pc_ld));
    check({tag, ".pc_ld_val"},  32'(bus.pc_ld_val),  32'(e.pc_ld_val));
    check({tag, ".ir_ld"},      32'(bus.ir_ld),      32'(e.ir_ld));
    check({tag, ".d_addr"},     32'(bus.d_addr),     32'(e.d_addr));
    check({tag, ".d_wr"},       32'(bus.d_wr),       32'(e.d_wr));
    check({tag, ".rf_s"},       32'(bus.rf_s),       32'(e.rf_s));
    check({tag, ".rf_imm"},     32'(bus.rf_imm),     32'(e.rf_imm));
    check({tag, ".rf_w_addr"},  32'(bus.rf_w_addr),  32'(e.rf_w_addr));
    check({tag, ".rf_w_wr"},    32'(bus.rf_w_wr),    32'(e.rf_w_wr));
    check({tag, ".rf_ra_addr"}, 32'(bus.rf_ra_addr), 32'(e.ra));
    check({tag, ".rf_rb_addr"}, 32'(bus.rf_rb_addr), 32'(e.rb));
    check({tag, ".alu_s"},      32'(bus.alu_s),      32'(e.alu_s));
    check({tag, ".halted"},     32'(bus.halted),     32'(e.halted));
  endtask

  function automatic exp_t blank(input logic [3:0] st);
    exp_t e;
    e = '{default: '0};
    e.state = st;
    return e;
  endfunction

  // Expected cycle-by-cycle trace of one instruction, starting at its fetch cycle.
  function automatic void build(input logic [15:0] ir_v, input logic zero);
    logic [3:0] op, ra, rb, rw;
    logic [7:0] addr;
    exp_t e;
    op = ir_v[15:12]; ra = ir_v[11:8]; addr = ir_v[7:0]; rb = ir_v[7:4]; rw = ir_v[3:0];
    e = blank(4'd1); e.pc_up = 1'b1; e.ir_ld = 1'b1; q.push_back(e);
    q.push_back(blank(4'd2));
    case (op)
      4'd0: q.push_back(blank(4'd3));
      4'd1: begin
        e = blank(4'd6); e.d_addr = addr; e.ra = ra; e.d_wr = 1'b1; q.push_back(e);
      end
      4'd2: begin
        for (int i = 0; i < MEM_LAT; i++) begin
          e = blank(4'd4); e.d_addr = addr; q.push_back(e);
        end
        e = blank(4'd5); e.d_addr = addr; e.rf_s = 2'd1; e.rf_w_addr = ra; e.rf_w_wr = 1'b1;
        q.push_back(e);
      end
      4'd3, 4'd4: begin
        e = blank(op == 4'd3 ? 4'd7 : 4'd8);
        e.ra = ra; e.rb = rb; e.rf_w_addr = rw; e.rf_w_wr = 1'b1;
        e.alu_s = (op == 4'd3) ? 3'd1 : 3'd2;
        q.push_back(e);
      end
      4'd6: begin
        e = blank(4'd10); e.rf_s = 2'd2; e.rf_imm = addr; e.rf_w_addr = ra; e.rf_w_wr = 1'b1;
        q.push_back(e);
      end
      4'd7: begin
        e = blank(4'd11); e.ra = ra; e.pc_ld_val = addr[6:0]; e.pc_ld = zero; q.push_back(e);
      end
      default: begin
        for (int i = 0; i < HALT_CY; i++) begin
          e = blank(4'd9); e.halted = 1'b1; q.push_back(e);
        end
      end
    endcase
  endfunction

  // Entered one delta past a posedge with the DUT in FETCH; max_cy < 0 runs the whole trace.
  task automatic run_instr(input string tag, input logic [15:0] ir_v, input logic zero,
                           input bit run_hi, input int max_cy);
    exp_t e;
    int   n;
    bus.ir       = ir_v;
    bus.alu_zero = zero;
    build(ir_v, zero);
    n = 0;
    while (q.size() > 0 && (max_cy < 0 || n < max_cy)) begin
      e = q.pop_front();
      bus.run = run_hi ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge clk);
      check_rec(tag, e);
      @(posedge clk);
      #1;
      n++;
    end
    q.delete();
  endtask

  task automatic do_reset(input string tag, input int idle);
    exp_t init_e;
    init_e = blank(4'd0);
    init_e.pc_clr = 1'b1;
    reset_n = 1'b0;
    #2;
    check_rec({tag, ".in_reset"}, init_e);
    @(posedge clk);
    #1;
    check_rec({tag, ".held"}, init_e);
    reset_n = 1'b1;
    bus.run = 1'b0;
    for (int i = 0; i < idle; i++) begin
      @(negedge clk);
      check_rec({tag, ".init_wait"}, init_e);
      @(posedge clk);
      #1;
    end
    bus.run = 1'b1;
    @(negedge clk);
    check_rec({tag, ".run_pending"}, init_e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0]  op;
    logic [15:0] rir;
    int          k;
    checks       = 0;
    errors       = 0;
    reset_n      = 1'b0;
    bus.run      = 1'b0;
    bus.ir       = '0;
    bus.alu_zero = 1'b0;
    #1;
    do_reset("por", 5);

    run_instr("store", 16'h1F29, 1'b0, 1'b0, -1);
    run_instr("load",  16'h20A7, 1'b0, 1'b0, -1);
    run_instr("add",   16'h3123, 1'b0, 1'b0, -1);
    run_instr("sub",   16'h4123, 1'b0, 1'b0, -1);
    run_instr("loadi", 16'h6355, 1'b0, 1'b0, -1);
    run_instr("jpz_z", 16'h7140, 1'b1, 1'b0, -1);
    run_instr("jpz_nz", 16'h7140, 1'b0, 1'b0, -1);
    run_instr("noop",  16'h0ABC, 1'b1, 1'b0, -1);

    for (int i = 0; i < 40; i++) begin
      k   = int'($urandom_range(0, 6));
      op  = (k < 5) ? 4'(k) : 4'(k + 1);
      rir = {op, 12'($urandom)};
      run_instr("rand", rir, 1'($urandom_range(0, 1)), 1'b0, -1);
    end

    // Abort a load in its second LOAD_A cycle, away from any clock edge.
    run_instr("abort_pre", 16'h20A7, 1'b0, 1'b0, 3);
    check("abort.in_load_a", 32'(bus.state), 32'd4);
    do_reset("abort", 2);

    run_instr("halt5", 16'h5000, 1'b0, 1'b1, -1);
    do_reset("rst_h", 1);
    run_instr("haltF", 16'hF000, 1'b0, 1'b1, -1);
    do_reset("rst_f", 1);
    run_instr("post_halt", 16'h3456, 1'b0, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
